// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Optional leading-zero blank mask enabled by LEADING_ZERO_BLANK_EN.
module bin2bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow,
  output logic [3:0]            blank
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic            overflow_q, overflow_d;

  logic                  accept;
  logic                  last_shift;
  logic [DW-1:0]         adj;
  logic [DW+WIDTH-1:0]   cat;
  logic [DW-1:0]         acc_sh;
  logic [WIDTH-1:0]      sh_sh;

  assign accept     = (state_q == IDLE) && start;
  assign last_shift = (state_q == SHIFT) &&
                      (cnt_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction precedes the shift of {acc, sh}
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    cat    = {adj, sh_q} << 1;
    acc_sh = cat[DW+WIDTH-1:WIDTH];
    sh_sh  = cat[WIDTH-1:0];
  end

  always_comb begin
    sh_d       = sh_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    if (accept) begin
      sh_d       = bin;
      acc_d      = '0;
      cnt_d      = '0;
      ovf_pend_d = {{(32-WIDTH){1'b0}}, bin} > 32'd9999;
    end else if (state_q == SHIFT) begin
      sh_d  = sh_sh;
      acc_d = acc_sh;
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Output logic (registered)
  always_comb begin
    busy_d     = (state_d == SHIFT);
    done_d     = last_shift;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    if (last_shift) begin
      digits_d   = ovf_pend_q ? {DIGITS{4'h9}} : acc_sh;
      overflow_d = ovf_pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign digits   = digits_q;
  assign overflow = overflow_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] blank_q, blank_d;

  always_comb begin
    blank_d = blank_q;
    if (last_shift) begin
      blank_d[3] = (digits_d[15:12] == 4'd0);
      blank_d[2] = blank_d[3] && (digits_d[11:8] == 4'd0);
      blank_d[1] = blank_d[2] && (digits_d[7:4] == 4'd0);
      blank_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 4'b0000;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: decimal reference model,
// driver pushes expectations, monitor pops on each done pulse.
module tb_bin2bcd_seq;

  localparam int W = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  bin;
  logic          busy;
  logic          done;
  logic [15:0]   digits;
  logic          overflow;
  logic [3:0]    blank;

  typedef struct {
    logic [15:0] d;
    logic        ovf;
    logic [3:0]  bl;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  bin2bcd_seq #(.WIDTH(W), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .digits   (digits),
    .overflow (overflow),
    .blank    (blank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Decimal reference: saturate, then split with / and %
  function automatic exp_t model(input int v, input int acc);
    exp_t e;
    int s;
    s = (v > 9999) ? 9999 : v;
    e.d   = {4'(s / 1000), 4'((s / 100) % 10),
             4'((s / 10) % 10), 4'(s % 10)};
    e.ovf = (v > 9999);
`ifdef LEADING_ZERO_BLANK_EN
    e.bl  = {s < 1000, s < 100, s < 10, 1'b0};
`else
    e.bl  = 4'b0000;
`endif
    e.acc = acc;
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (busy && done) begin
      chk("busy_and_done", 1, 0);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("latency", cyc - e.acc, W);
        chk("digits", int'(digits), int'(e.d));
        chk("overflow", int'(overflow), int'(e.ovf));
        chk("blank", int'(blank), int'(e.bl));
      end
    end
  end

  task automatic issue(input int v);
    @(negedge clk);
    bin   = W'(v);
    start = 1'b1;
    exp_q.push_back(model(v, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    bin   = W'($urandom);
    repeat (W) @(negedge clk);
  endtask

  initial begin
    int k;
    rst   = 1'b1;
    start = 1'b1;
    bin   = W'(1234);
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_digits", int'(digits), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_blank", int'(blank), 0);
    end
    rst = 1'b0;
    exp_q.push_back(model(1234, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);

    issue(0);
    issue(9999);
    issue(12000);
    issue(7);
    issue(16383);
    issue(42);

    for (int i = 0; i < 20; i++) begin
      issue(int'($urandom_range(0, (1 << W) - 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Second start during busy must be ignored
    @(negedge clk);
    bin   = W'(500);
    start = 1'b1;
    exp_q.push_back(model(500, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    bin   = W'(321);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2 * W + 4) @(negedge clk);
    chk("ignored_start_q", exp_q.size(), 0);

    // Reset at cycle 7 of a conversion discards it
    @(negedge clk);
    bin   = W'(4321);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_digits", int'(digits), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ovf", int'(overflow), 0);
    repeat (W + 4) @(negedge clk);

    // Continuous start: one conversion every W+1 cycles
    @(negedge clk);
    k     = cyc + 1;
    start = 1'b1;
    bin   = W'(1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(i + 1, k + (W + 1) * i));
    end
    repeat (W + 1) @(negedge clk);
    bin = W'(2);
    repeat (W + 1) @(negedge clk);
    bin = W'(3);
    @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 1000) begin
        @(negedge clk);
        t++;
      end
      chk("drain_q", exp_q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that feeds the four-digit seven-segment scan driver. It accepts a binary value on a start pulse and produces four packed BCD digits. Completion is signalled with a one-cycle done pulse. The digits are held stable between conversions so the downstream multiplexer can scan them continuously.

## Interface
- WIDTH, 14, binary input width; legal range 4..14.
- DIGITS, 4, number of BCD digits; fixed at 4 for this design.

- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  binary value; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when `digits` is updated.
- digits  output  16  packed BCD; [3:0] is the ones digit, [15:12] is the thousands digit.
- overflow  output  1  high when the last accepted `bin` was greater than 9999.
- blank  output  4  leading-zero blank mask, one bit per digit (see Configuration).

## Operation
- Reset value of every output is 0.
- FSM states:
  - IDLE: waits for a request.
  - SHIFT: performs one shift per cycle.
- Transitions:
  - IDLE → SHIFT when `start`=1.
  - SHIFT → IDLE after exactly WIDTH shift cycles.
- Accept edge (IDLE, `start`=1):
  - Load `bin` into the shift register.
  - Clear the internal BCD accumulator.
  - Set the bit counter to 0.
  - `busy`=1.
- Each SHIFT edge:
  - Add 3 to every accumulator nibble that is ≥5.
  - Then shift {accumulator, shift register} left by 1.
  - Increment the counter.
- Final shift edge (counter reaches WIDTH−1):
  - Register the result into `digits`.
  - `done`=1, `busy`=0, state returns to IDLE.
  - `overflow` is computed and registered on this same edge.
- Overflow rule: if the accepted value is >9999, `digits` saturates to 16'h9999 and `overflow`=1. Otherwise `overflow`=0.
- Held values: `digits`, `overflow` and `blank` hold until the next final-shift edge or reset.
- `start` while `busy`=1 is ignored; it is not queued.
- `start` during the `done` cycle is accepted, since the FSM is already in IDLE.
- Changes on `bin` after the accept edge have no effect.
- Reset mid-conversion: on the next edge the FSM returns to IDLE and every output is 0. The partial result is discarded.
- Reset has priority over `start` on the same edge.

## Timing
- Latency: `start` is sampled at edge E0 and `done` is high in the cycle after edge E(WIDTH). For WIDTH=14, that is 14 edges after acceptance.
- `busy` is high from after E0 until after E(WIDTH), so it spans WIDTH cycles.
- `done` is high for exactly one cycle and is never asserted together with `busy`.
- Back-to-back conversions: the minimum period is WIDTH+1 cycles when `start` is held high continuously.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - `blank[i]`=1 when digit i and every higher digit are 0, for i=1..3.
  - `blank[0]` is always 0.
  - `blank` updates on the same edge as `digits`.
  - Example: value 0042 gives `blank`=4'b1100.
- LEADING_ZERO_BLANK_EN undefined: the `blank` port is still present and is tied to 4'b0000. No blanking logic is synthesised.

## Test plan
- Reset with `bin`=1234 and `start`=1 held: all outputs stay 0. On the first cycle after release, the conversion is accepted and `done` pulses 14 cycles later with `digits`=16'h1234.
- `bin`=0: `digits`=16'h0000, `overflow`=0. `blank`=4'b1110 with the macro defined, 4'b0000 without it.
- `bin`=9999 → `digits`=16'h9999, `overflow`=0. `bin`=12000 → `digits`=16'h9999, `overflow`=1. A following `bin`=7 → `digits`=16'h0007 and `overflow` clears to 0.
- Mid-conversion stimulus:
  - Pulse `start` with `bin`=500, then change `bin` to 321 and pulse `start` again 5 cycles later: exactly one `done` occurs, with `digits`=16'h0500.
  - Assert `rst` for 1 cycle at cycle 7 of a conversion: no `done` occurs, `busy` is 0 and `digits` is 0 the cycle after reset.
- Hold `start`=1 continuously over values 1, 2, 3: `done` pulses every 15 cycles with digits 0001, 0002, 0003. `busy` and `done` are never high together.
